// File: rtl/kypd_pkg.sv
// Shared definitions for the keypad digit-entry path: FSM states, key map,
// entry sizing and small scan helpers.
package kypd_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned ENTRY_W    = NUM_DIGITS * CODE_W;
  localparam int unsigned CNT_W      = 4;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } kypd_state_t;

  // Hex code per [row][col] of the Pmod KYPD layout.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // True when exactly one line of an active-low group is asserted.
  function automatic logic single_low(input logic [3:0] v);
    logic r;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Index of the low line in a one-cold group (0 when not one-cold).
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Advance the one-cold column drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] rotate_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/kypd_scan_timer.sv
// Column dwell timer: counts modulo SCAN_DIV and flags the last cycle of
// each column period. Pause holds the count at zero so a resumed scan
// always gets a full column period.
module kypd_scan_timer
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic sample_tick_c
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running dwell counter, cleared while the FSM has a column frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (pause) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sample_tick_c = (cnt == LAST) && !pause;

endmodule

// File: rtl/keypad_digit_entry.sv
// 4x4 keypad scanner with debounce and an 8-digit shift-in entry register.
// Define KYPD_ENTRY_EN to build the entry register, digit count, full flag
// and clear handling; without it those outputs are tied to zero.
module keypad_digit_entry
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          row,
  output logic [3:0]          col,
  input  logic                clr,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic [ENTRY_W-1:0]  entry,
  output logic [CNT_W-1:0]    digit_cnt,
  output logic                entry_full
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  kypd_state_t       state;
  kypd_state_t       state_nxt;
  logic [3:0]        col_nxt;
  logic [3:0]        row_cap;
  logic [3:0]        row_cap_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic [CODE_W-1:0] key_code_nxt;
  logic              key_valid_nxt;
  logic              sample_tick_c;
  logic              scan_pause_c;

  // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= ROWS_IDLE;
      row_sync <= ROWS_IDLE;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign scan_pause_c = (state != SCAN);

  kypd_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .pause         (scan_pause_c),
    .sample_tick_c (sample_tick_c)
  );

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col       <= COL_RESET;
      row_cap   <= ROWS_IDLE;
      db_cnt    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row_cap   <= row_cap_nxt;
      db_cnt    <= db_cnt_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  // Next-state logic: scan columns, debounce the press, wait for release.
  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_cap_nxt   = row_cap;
    db_cnt_nxt    = db_cnt;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;

    case (state)
      SCAN: begin
        if (sample_tick_c) begin
          if (single_low(row_sync)) begin
            state_nxt   = CONFIRM;
            row_cap_nxt = row_sync;
            db_cnt_nxt  = '0;
          end else begin
            col_nxt = rotate_col(col);
          end
        end
      end

      CONFIRM: begin
        if (row_sync == row_cap) begin
          if (db_cnt == DB_LAST) begin
            state_nxt     = HELD;
            db_cnt_nxt    = '0;
            key_valid_nxt = 1'b1;
            key_code_nxt  = KEY_MAP[low_index(row_cap)][low_index(col)];
          end else begin
            db_cnt_nxt = db_cnt + DB_W'(1);
          end
        end else begin
          state_nxt  = SCAN;
          db_cnt_nxt = '0;
          col_nxt    = rotate_col(col);
        end
      end

      HELD: begin
        // Any low row, including a second key, restarts the release count.
        if (row_sync == ROWS_IDLE) begin
          if (db_cnt == DB_LAST) begin
            state_nxt  = SCAN;
            db_cnt_nxt = '0;
            col_nxt    = rotate_col(col);
          end else begin
            db_cnt_nxt = db_cnt + DB_W'(1);
          end
        end else begin
          db_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt  = SCAN;
        col_nxt    = COL_RESET;
        db_cnt_nxt = '0;
      end
    endcase
  end

`ifdef KYPD_ENTRY_EN
  // Shift accepted digits in at the low nibble; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry     <= '0;
      digit_cnt <= '0;
    end else if (clr) begin
      entry     <= '0;
      digit_cnt <= '0;
    end else if (key_valid) begin
      entry <= {entry[ENTRY_W-CODE_W-1:0], key_code};
      if (digit_cnt != CNT_W'(NUM_DIGITS)) begin
        digit_cnt <= digit_cnt + CNT_W'(1);
      end
    end
  end

  assign entry_full = (digit_cnt == CNT_W'(NUM_DIGITS));
`else
  logic clr_unused;

  assign entry      = '0;
  assign digit_cnt  = '0;
  assign entry_full = 1'b0;
  assign clr_unused = clr;
`endif

endmodule
